// File: rtl/load_issue_queue.sv
// load_issue_queue: load reservation station between rename/dispatch and the memory arbiter.
// Accepts up to PUSH_WIDTH loads per cycle, tracks base-register readiness and an older-store
// dependency per entry, wakes entries from NUM_CDB broadcast ports and a store-done port, and
// presents one ready load per cycle over a valid/ready handshake. Entries free themselves on
// an issue handshake.
//
// Optional feature: define LOAD_IQ_AGE_SELECT_EN to select the oldest ready entry through a
// DEPTH x DEPTH age matrix. Default build selects the lowest-index ready entry and holds a
// presented entry until it is accepted, flushed or reset.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   num_push_i            number of dispatch slots written this cycle (slots 0..num_push_i-1)
//   push_*_i              per-slot base preg, preg ready, store dependency, dep ROB, payload
//   push_limit_o          registered min(PUSH_WIDTH, free entries)
//   cdb_valid_i/preg_i    wakeup broadcast ports
//   store_done_*_i        resolved store ROB number
//   flush_i               squash all entries; drops same-cycle pushes
//   issue_valid_o/ready_i issue handshake; issue_preg_o / issue_payload_o of presented entry
//   occupancy_o           registered count of valid entries
module load_issue_queue #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned PUSH_WIDTH = 2,
    parameter int unsigned NUM_CDB    = 2,
    parameter int unsigned PREG_BITS  = 6,
    parameter int unsigned ROB_BITS   = 5,
    parameter int unsigned PAYLOAD_W  = 64,
    localparam int unsigned CNT_W     = $clog2(PUSH_WIDTH + 1),
    localparam int unsigned OCC_W     = $clog2(DEPTH + 1),
    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [CNT_W-1:0]                     num_push_i,
    input  logic [PUSH_WIDTH-1:0][PREG_BITS-1:0] push_preg_i,
    input  logic [PUSH_WIDTH-1:0]                push_preg_ready_i,
    input  logic [PUSH_WIDTH-1:0]                push_has_dep_i,
    input  logic [PUSH_WIDTH-1:0][ROB_BITS-1:0]  push_dep_rob_i,
    input  logic [PUSH_WIDTH-1:0][PAYLOAD_W-1:0] push_payload_i,
    output logic [CNT_W-1:0]                     push_limit_o,
    input  logic [NUM_CDB-1:0]                   cdb_valid_i,
    input  logic [NUM_CDB-1:0][PREG_BITS-1:0]    cdb_preg_i,
    input  logic                                 store_done_valid_i,
    input  logic [ROB_BITS-1:0]                  store_done_rob_i,
    input  logic                                 flush_i,
    output logic                                 issue_valid_o,
    input  logic                                 issue_ready_i,
    output logic [PREG_BITS-1:0]                 issue_preg_o,
    output logic [PAYLOAD_W-1:0]                 issue_payload_o,
    output logic [OCC_W-1:0]                     occupancy_o
);

    // Entry state
    logic [DEPTH-1:0]                valid_q, valid_d;
    logic [DEPTH-1:0][PREG_BITS-1:0] preg_q, preg_d;
    logic [DEPTH-1:0]                rdy_q, rdy_d;
    logic [DEPTH-1:0]                dep_q, dep_d;
    logic [DEPTH-1:0][ROB_BITS-1:0]  drob_q, drob_d;
    logic [PAYLOAD_W-1:0]            pay_q [DEPTH];
    logic [PAYLOAD_W-1:0]            pay_d [DEPTH];
    logic [OCC_W-1:0]                occ_q, occ_d;
    logic [CNT_W-1:0]                plim_q, plim_d;

    logic [DEPTH-1:0]                ready;
    logic [DEPTH-1:0]                rdy_wake, dep_wake;
    logic                            sel_found;
    logic [IDX_W-1:0]                sel_idx;
    logic                            accept;

    logic [PUSH_WIDTH-1:0]           slot_ok, push_en, push_cdb_hit, push_sd_hit;
    logic [PUSH_WIDTH-1:0][IDX_W-1:0] slot_idx;
    logic [DEPTH-1:0]                taken;

    assign ready = valid_q & rdy_q & ~dep_q;

    // Wakeup of resident entries from CDB and store-done broadcasts
    always_comb begin
        rdy_wake = rdy_q;
        dep_wake = dep_q;
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < NUM_CDB; k++) begin
                if (valid_q[i] && cdb_valid_i[k] && (preg_q[i] == cdb_preg_i[k])) begin
                    rdy_wake[i] = 1'b1;
                end
            end
            if (store_done_valid_i && dep_q[i] && (drob_q[i] == store_done_rob_i)) begin
                dep_wake[i] = 1'b0;
            end
        end
    end

    // Capture bypass for the entries being written this cycle
    always_comb begin
        push_cdb_hit = '0;
        push_sd_hit  = '0;
        for (int s = 0; s < PUSH_WIDTH; s++) begin
            for (int k = 0; k < NUM_CDB; k++) begin
                if (cdb_valid_i[k] && (cdb_preg_i[k] == push_preg_i[s])) begin
                    push_cdb_hit[s] = 1'b1;
                end
            end
            push_sd_hit[s] = store_done_valid_i && (store_done_rob_i == push_dep_rob_i[s]);
        end
    end

    // Slot s takes the s-th lowest free entry; entries freed by this cycle's issue still
    // count as occupied, so they are only reusable next cycle.
    always_comb begin
        taken    = '0;
        slot_ok  = '0;
        slot_idx = '0;
        push_en  = '0;
        for (int s = 0; s < PUSH_WIDTH; s++) begin
            for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
                if (!valid_q[i] && !taken[i]) begin
                    slot_ok[s]  = 1'b1;
                    slot_idx[s] = IDX_W'(i);
                end
            end
            if (slot_ok[s]) begin
                taken[slot_idx[s]] = 1'b1;
            end
            push_en[s] = slot_ok[s] && (s < int'(num_push_i)) && !flush_i;
        end
    end

`ifdef LOAD_IQ_AGE_SELECT_EN
    // older_q[j][i] set means entry j is older than entry i.
    logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;
    logic [DEPTH-1:0]            pushed;
    logic [DEPTH-1:0]            oldest;

    always_comb begin
        oldest    = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            oldest[i] = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (ready[j] && older_q[j][i]) begin
                    oldest[i] = 1'b0;
                end
            end
        end
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (oldest[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // A new entry is younger than every resident entry and every lower pushed slot.
    always_comb begin
        older_d = older_q;
        pushed  = '0;
        for (int s = 0; s < PUSH_WIDTH; s++) begin
            if (push_en[s]) begin
                for (int j = 0; j < DEPTH; j++) begin
                    older_d[j][slot_idx[s]] = valid_q[j] | pushed[j];
                    older_d[slot_idx[s]][j] = 1'b0;
                end
                pushed[slot_idx[s]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            older_q <= '0;
        end else begin
            older_q <= older_d;
        end
    end
`else
    // A presented but not accepted entry stays selected; readiness never drops, so the
    // held entry is still ready next cycle.
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
        if (lock_q) begin
            sel_found = 1'b1;
            sel_idx   = lock_idx_q;
        end
    end

    assign lock_d     = issue_valid_o & ~issue_ready_i;
    assign lock_idx_d = sel_idx;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end
`endif

    assign issue_valid_o   = sel_found & ~flush_i;
    assign issue_preg_o    = preg_q[sel_idx];
    assign issue_payload_o = pay_q[sel_idx];
    assign accept          = issue_valid_o & issue_ready_i;

    // Next entry state
    always_comb begin
        valid_d = valid_q;
        preg_d  = preg_q;
        rdy_d   = rdy_wake;
        dep_d   = dep_wake;
        drob_d  = drob_q;
        pay_d   = pay_q;
        if (accept) begin
            valid_d[sel_idx] = 1'b0;
        end
        for (int s = 0; s < PUSH_WIDTH; s++) begin
            if (push_en[s]) begin
                valid_d[slot_idx[s]] = 1'b1;
                preg_d[slot_idx[s]]  = push_preg_i[s];
                rdy_d[slot_idx[s]]   = push_preg_ready_i[s] | push_cdb_hit[s];
                dep_d[slot_idx[s]]   = push_has_dep_i[s] & ~push_sd_hit[s];
                drob_d[slot_idx[s]]  = push_dep_rob_i[s];
                pay_d[slot_idx[s]]   = push_payload_i[s];
            end
        end
        if (flush_i) begin
            valid_d = '0;
        end
    end

    // Registered occupancy and push limit describe the post-edge state
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end
        if ((OCC_W'(DEPTH) - occ_d) >= OCC_W'(PUSH_WIDTH)) begin
            plim_d = CNT_W'(PUSH_WIDTH);
        end else begin
            plim_d = CNT_W'(OCC_W'(DEPTH) - occ_d);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            occ_q   <= '0;
            plim_q  <= CNT_W'(PUSH_WIDTH);
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            plim_q  <= plim_d;
        end
    end

    // Data fields need no reset; they are only observed behind valid_q
    always_ff @(posedge clk_i) begin
        preg_q <= preg_d;
        rdy_q  <= rdy_d;
        dep_q  <= dep_d;
        drob_q <= drob_d;
        pay_q  <= pay_d;
    end

    assign occupancy_o  = occ_q;
    assign push_limit_o = plim_q;

    push_within_limit: assert property (@(posedge clk_i) disable iff (rst_i)
        num_push_i <= push_limit_o);

endmodule

// File: doc/load_issue_queue.md
# load_issue_queue

Parametrised load reservation station that sits between rename/dispatch and the load/memory arbiter. It accepts up to PUSH_WIDTH loads per cycle and tracks each entry's base-register readiness and store dependency. It also performs its own wakeup from multiple CDB ports and selects one ready load per cycle to issue over a valid/ready handshake. Unlike the previous generation, slot freeing is internal on issue handshake, not driven by an external free index.

## Interface
Parameters:
- DEPTH, 8: number of entries; must be ≥ PUSH_WIDTH.
- PUSH_WIDTH, 2: dispatch slots per cycle.
- NUM_CDB, 2: wakeup broadcast ports.
- PREG_BITS, 6: physical register index width.
- ROB_BITS, 5: ROB number width.
- PAYLOAD_W, 64: opaque load payload (imm, funct3, rd, rob) carried untouched.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- num_push  in  $clog2(PUSH_WIDTH+1)  slots 0..num_push-1 are written this cycle.
- push_preg  in  PUSH_WIDTH×PREG_BITS  base-address physical register per slot.
- push_preg_ready  in  PUSH_WIDTH  base register already valid in the register file.
- push_has_dep  in  PUSH_WIDTH  slot must wait for an older store.
- push_dep_rob  in  PUSH_WIDTH×ROB_BITS  ROB number of that store.
- push_payload  in  PUSH_WIDTH×PAYLOAD_W  payload per slot.
- push_limit  out  $clog2(PUSH_WIDTH+1)  equals min(PUSH_WIDTH, free entries).
- cdb_valid  in  NUM_CDB  broadcast valid.
- cdb_preg  in  NUM_CDB×PREG_BITS  broadcast physical register.
- store_done_valid  in  1  a store address has resolved.
- store_done_rob  in  ROB_BITS  ROB number of the resolved store.
- flush  in  1  mispredict; squash all entries.
- issue_valid  out  1  a ready entry is presented.
- issue_ready  in  1  memory side accepts.
- issue_preg  out  PREG_BITS  base register of the presented entry.
- issue_payload  out  PAYLOAD_W  payload of the presented entry.
- occupancy  out  $clog2(DEPTH+1)  number of valid entries.

## Operation
- Entry state: valid, preg, preg_rdy, dep_pend, dep_rob, payload. An entry is ready when valid & preg_rdy & ~dep_pend.
- Push: slot i < num_push goes to the i-th lowest-index free entry. num_push > push_limit is illegal and must be flagged by an assertion.
- Capture bypass: if a CDB port in the push cycle matches push_preg, the entry is captured with preg_rdy=1. If store_done matches push_dep_rob in the push cycle, the entry is captured with dep_pend=0.
- Wakeup: each cycle, every valid entry with preg == cdb_preg[k] and cdb_valid[k] set sets preg_rdy. Every entry with dep_pend and dep_rob == store_done_rob clears dep_pend.
- Select: picks one ready entry (policy under Configuration). issue_* is combinational from registered state. On issue_valid & issue_ready, the entry's valid clears at the next edge.
- Free space: an entry freed by issue is reusable by a push in the following cycle, not in the same cycle.
- Flush: all valid bits clear at the next edge. Pushes in the flush cycle are dropped. issue_valid is forced to 0 while flush is high.
- Reset: all entries invalid, issue_valid=0, occupancy=0, push_limit=min(PUSH_WIDTH,DEPTH), age state cleared.

## Timing
- Push at edge t: the entry is visible and issue_valid can assert in cycle t+1 if it was ready on capture.
- Wakeup during cycle t allows issue in t+1, a one-cycle wake-to-issue latency.
- push_limit and occupancy are registered. They reflect the state after the edge, including that edge's pushes and issues.
- Stalls: issue_valid stays high with a stable payload while issue_ready=0, unless flush or rst. An older entry becoming ready may change the selection only with the macro enabled.
- Full: push_limit=0 and all dispatch stalls. Empty: issue_valid=0.
- rst takes priority over flush. Both take priority over push and issue.

## Configuration
- LOAD_IQ_AGE_SELECT_EN defined:
  - A DEPTH×DEPTH age matrix selects the oldest ready entry.
  - Same-cycle pushes: a lower slot index is older.
  - A presented entry may be replaced by an older ready entry only while issue_ready=0.
- Not defined:
  - Selection uses the lowest-index ready entry and there is no age matrix.
  - A presented entry stays selected until accepted, flushed, or reset.

## Test plan
- Reset, then push 2 loads (preg 5 and 6 ready, no dep) -> in cycle t+1 issue_valid=1 with preg 5; push_limit=2; occupancy=2.
- Push preg 9 not ready, then cdb_preg[1]=9 two cycles later -> issue_valid asserts exactly one cycle after the broadcast.
- Push with push_has_dep=1, dep_rob=3; store_done_rob=4 then 3 -> the load issues only after rob 3 resolves. Also push with a same-cycle store_done of rob 3 -> the load is ready at t+1.
- Fill all 8 entries with issue_ready=0 -> push_limit=0, occupancy=8. Accept one -> push_limit=1 the following cycle.
- With flush during a push of 2 and 5 valid entries -> occupancy=0 and issue_valid=0 next cycle, push_limit=2.
- Macro on: push A (index 0, not ready) then B (ready), then wake A -> A issues before B. Macro off: B issues first if presented before A woke; otherwise lowest index.
